// File: rtl/fb_page_arbiter_pkg.sv
// Shared framebuffer geometry and page-swap FSM encodings.
// Geometry: one 64x32 rgb565 page is 4096 bytes, and the scan has 16 rows.
package fb_page_arbiter_pkg;

  localparam int FB_PAGE_ADDR_WIDTH = 12;
  localparam int FB_DATA_WIDTH      = 8;
  localparam int FB_ROW_WIDTH       = 4;

  typedef enum logic [1:0] {
    FB_SWAP_IDLE       = 2'd0,
    FB_SWAP_WAIT_FRAME = 2'd1,
    FB_SWAP_SWAP       = 2'd2
  } fb_swap_state_t;

endpackage

// File: rtl/fb_page_arbiter_rr.sv
// Two-way round-robin grant. The ready signals are combinational, with zero latency, and last_grant holds the previous winner.
// Backpressure: block forces both readies low, and a losing writer holds its request.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic block,
  output logic ready0,
  output logic ready1
);

  logic last_grant;

  // On contention the writer that did not win last time goes first.
  always_comb begin
    ready0 = valid0 && !block && (!valid1 || last_grant);
    ready1 = valid1 && !block && (!valid0 || !last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (ready0 || ready1) begin
      last_grant <= ready1;
    end
  end

endmodule

// File: rtl/fb_page_arbiter.sv
// Double-buffered framebuffer write arbiter with a page swap that is aligned to the frame wrap.
// Write latency to the RAM port is 1 cycle. Backpressure: the losing writer and every writer during the SWAP cycle see ready low.
module fb_page_arbiter
  import fb_page_arbiter_pkg::*;
#(
  parameter int PAGE_ADDR_WIDTH = FB_PAGE_ADDR_WIDTH,
  parameter int DATA_WIDTH      = FB_DATA_WIDTH,
  parameter int ROW_WIDTH       = FB_ROW_WIDTH
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       req0_valid,
  input  logic [PAGE_ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [PAGE_ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  output logic                       req1_ready,
  input  logic                       swap_request,
  input  logic [ROW_WIDTH-1:0]       row_address,
  output logic [PAGE_ADDR_WIDTH:0]   ram_address,
  output logic [DATA_WIDTH-1:0]      ram_data_out,
  output logic                       ram_write_enable,
  output logic                       ram_clk_enable,
  output logic                       read_page,
  output logic                       swap_pending,
  output logic                       swap_done
);

  fb_swap_state_t       state;
  logic [ROW_WIDTH-1:0] row_q;
  logic                 wrap;
  logic                 write_page;
  logic                 xfer;

  assign write_page     = ~read_page;
  assign wrap           = (row_q == {ROW_WIDTH{1'b1}}) && (row_address == '0);
  assign xfer           = req0_ready || req1_ready;
  assign swap_pending   = (state == FB_SWAP_WAIT_FRAME);
  assign ram_clk_enable = ram_write_enable;

  rr_arbiter2 u_arb (
    .clk    (clk_in),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .block  (state == FB_SWAP_SWAP),
    .ready0 (req0_ready),
    .ready1 (req1_ready)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state            <= FB_SWAP_IDLE;
      read_page        <= 1'b0;
      swap_done        <= 1'b0;
      row_q            <= '0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_out     <= '0;
    end else begin
      row_q            <= row_address;
      swap_done        <= 1'b0;
      ram_write_enable <= xfer;
      // The page bit is captured with the write, so a swap can never split a transfer.
      if (xfer) begin
        ram_address  <= {write_page, (req1_ready ? req1_addr : req0_addr)};
        ram_data_out <= req1_ready ? req1_data : req0_data;
      end
      case (state)
        FB_SWAP_IDLE: begin
          if (swap_request) state <= FB_SWAP_WAIT_FRAME;
        end
        FB_SWAP_WAIT_FRAME: begin
          if (wrap) state <= FB_SWAP_SWAP;
        end
        FB_SWAP_SWAP: begin
          read_page <= ~read_page;
          swap_done <= 1'b1;
          state     <= swap_request ? FB_SWAP_WAIT_FRAME : FB_SWAP_IDLE;
        end
        default: state <= FB_SWAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_page_arbiter.sv
// Directed bench for fb_page_arbiter: a cycle model is checked on every falling edge, and the directed scenarios add literal checks.
module tb_fb_page_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [11:0] req0_addr, req1_addr;
  logic [7:0]  req0_data, req1_data;
  logic        swap_request;
  logic [3:0]  row_address;
  logic [12:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable, ram_clk_enable;
  logic        read_page, swap_pending, swap_done;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  fb_page_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .swap_request(swap_request), .row_address(row_address),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .read_page(read_page), .swap_pending(swap_pending), .swap_done(swap_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. The phases are "pending until a wrap" and "this is the swap cycle".
  bit          m_on = 1'b0;
  bit          m_rp, m_pend, m_swap, m_done, m_last, m_we;
  logic [3:0]  m_rowq;
  logic [12:0] m_addr;
  logic [7:0]  m_data;

  always @(negedge clk_in) begin : model
    int winner;
    bit wrap;
    winner = -1;
    if (!m_swap) begin
      if (req0_valid && req1_valid) winner = m_last ? 0 : 1;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
    end
    if (m_on) begin
      chk("model_ready0", req0_ready, winner == 0);
      chk("model_ready1", req1_ready, winner == 1);
      chk("model_we", ram_write_enable, m_we);
      chk("model_clk_en", ram_clk_enable, m_we);
      if (m_we) begin
        chk("model_addr", ram_address, m_addr);
        chk("model_data", ram_data_out, m_data);
      end
      chk("model_read_page", read_page, m_rp);
      chk("model_swap_pending", swap_pending, m_pend);
      chk("model_swap_done", swap_done, m_done);
    end
    if (reset) begin
      m_on = 1'b1; m_rp = 0; m_pend = 0; m_swap = 0; m_done = 0; m_last = 1; m_we = 0;
      m_rowq = 4'd0; m_addr = 13'd0; m_data = 8'd0;
    end else if (m_on) begin
      wrap = (m_rowq == 4'd15) && (row_address == 4'd0);
      m_we = (winner >= 0);
      if (winner == 0) begin m_addr = {!m_rp, req0_addr}; m_data = req0_data; m_last = 0; end
      if (winner == 1) begin m_addr = {!m_rp, req1_addr}; m_data = req1_data; m_last = 1; end
      m_done = m_swap;
      if (m_swap) begin
        m_rp = !m_rp; m_pend = swap_request; m_swap = 0;
      end else if (m_pend) begin
        if (wrap) begin m_pend = 0; m_swap = 1; end
      end else if (swap_request) begin
        m_pend = 1;
      end
      m_rowq = row_address;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int n0, n1;
    reset = 1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_data = 0; req1_data = 0; swap_request = 0; row_address = 0;
    tick(); tick();
    reset = 0;

    // 1: a single write lands in back page 1
    chk("t1_read_page", read_page, 1'b0);
    chk("t1_we_reset", ram_write_enable, 1'b0);
    req0_valid = 1; req0_addr = 12'h123; req0_data = 8'hAB;
    #1 chk("t1_ready0", req0_ready, 1'b1);
    tick();
    chk("t1_addr", ram_address, 13'h1123);
    chk("t1_data", ram_data_out, 8'hAB);
    chk("t1_we", ram_write_enable, 1'b1);
    req0_valid = 0;

    // 2: contention alternates, starting with writer 0 after reset
    reset = 1; tick(); reset = 0;
    n0 = 0; n1 = 0;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      req0_addr = 12'h010 + 12'(n0); req0_data = 8'h10 + 8'(n0);
      req1_addr = 12'h020 + 12'(n1); req1_data = 8'h20 + 8'(n1);
      #1;
      chk("t2_ready0", req0_ready, (k % 2) == 0);
      chk("t2_ready1", req1_ready, (k % 2) == 1);
      chk("t2_not_both", req0_ready & req1_ready, 1'b0);
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // 3: a swap requested at row 5 takes effect on the 15->0 wrap
    row_address = 4'd5; swap_request = 1; tick(); swap_request = 0;
    chk("t3_pending", swap_pending, 1'b1);
    for (int r = 6; r <= 15; r++) begin
      row_address = 4'(r); tick();
      chk("t3_pending_hold", swap_pending, 1'b1);
    end
    row_address = 4'd0; tick();
    req0_valid = 1; req0_addr = 12'h055; req0_data = 8'h5A;
    #1;
    chk("t3_swap_ready0", req0_ready, 1'b0);
    chk("t3_swap_pending_low", swap_pending, 1'b0);
    chk("t3_swap_old_page", read_page, 1'b0);
    tick();
    chk("t3_read_page", read_page, 1'b1);
    chk("t3_swap_done", swap_done, 1'b1);
    #1 chk("t3_ready_after", req0_ready, 1'b1);
    tick();
    chk("t3_done_pulse", swap_done, 1'b0);
    chk("t3_addr_page0", ram_address, 13'h0055);
    chk("t3_we", ram_write_enable, 1'b1);
    req0_valid = 0;

    // 5: reset in WAIT_FRAME while req1 transfers
    swap_request = 1; tick(); swap_request = 0;
    chk("t5_pending", swap_pending, 1'b1);
    req1_valid = 1; req1_addr = 12'h0AA; req1_data = 8'h77; reset = 1;
    tick();
    chk("t5_read_page", read_page, 1'b0);
    chk("t5_pending", swap_pending, 1'b0);
    chk("t5_we", ram_write_enable, 1'b0);
    reset = 0; req1_valid = 0;

    // 4: a request on the wrap cycle waits for the next wrap
    row_address = 4'd15; tick();
    row_address = 4'd0; swap_request = 1; tick(); swap_request = 0;
    chk("t4_pending", swap_pending, 1'b1);
    row_address = 4'd1; tick();
    chk("t4_no_swap_yet", swap_pending, 1'b1);
    for (int r = 2; r <= 15; r++) begin
      row_address = 4'(r); tick();
    end
    chk("t4_page_unchanged", read_page, 1'b0);
    row_address = 4'd0; tick();
    chk("t4_swap_cycle", swap_pending, 1'b0);
    tick();
    chk("t4_read_page", read_page, 1'b1);
    chk("t4_swap_done", swap_done, 1'b1);

    // 6: a request during SWAP re-arms the swap for the following wrap
    swap_request = 1; tick(); swap_request = 0;
    row_address = 4'd15; tick();
    row_address = 4'd0; tick();
    swap_request = 1; tick(); swap_request = 0;
    chk("t6_first_toggle", read_page, 1'b0);
    chk("t6_done", swap_done, 1'b1);
    chk("t6_rearmed", swap_pending, 1'b1);
    row_address = 4'd15; tick();
    chk("t6_wait", read_page, 1'b0);
    row_address = 4'd0; tick();
    tick();
    chk("t6_second_toggle", read_page, 1'b1);
    chk("t6_done2", swap_done, 1'b1);
    chk("t6_idle", swap_pending, 1'b0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
